sys_timer_master: RTL and testbench

// - Avalon-MM initiator that drives the system interval-timer slave (8 x 16-bit regs, 1-cycle rd latency).
// - Enables the timer IRQ, waits for it, clears the status, counts ticks for a hardware tick counter.
// - Sits beside the timer in the NIOS system; no CPU involvement needed.

---
 rtl/sys_timer_pkg.sv | 38 +++
 rtl/sys_timer_master.sv | 223 ++++++++++++++++++++++
 tb/tb_sys_timer_master.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_timer_pkg.sv
// -----------------------------------------------------------------------------
// sys_timer_pkg
// Shared constants and types for the system-timer Avalon-MM initiator.
//   - Register addresses of the interval-timer slave (8 x 16-bit registers).
//   - Control-register interrupt-enable bit (ITO).
//   - FSM state encoding used by sys_timer_master.
// Build option: the snapshot states are used only when TIMER_SNAPSHOT_EN is
// defined, and stay in the enum either way so the encoding is stable.
// -----------------------------------------------------------------------------
package sys_timer_pkg;

  // Timer slave register map
  localparam logic [2:0] REG_STATUS  = 3'd0;  // write clears timeout
  localparam logic [2:0] REG_CONTROL = 3'd1;  // bit CTRL_ITO = irq enable
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;  // write latches counter snapshot
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // Control register: interrupt-on-timeout enable
  localparam int          CTRL_ITO      = 0;
  localparam logic [15:0] CTRL_ITO_MASK = 16'h0001 << CTRL_ITO;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_EN_CTRL   = 4'd1,
    ST_WAIT_IRQ  = 4'd2,
    ST_CLR       = 4'd3,
    ST_GUARD     = 4'd4,
    ST_DIS_CTRL  = 4'd5,
    ST_SNAP_WR   = 4'd6,
    ST_SNAP_RD_L = 4'd7,
    ST_SNAP_WT_L = 4'd8,
    ST_SNAP_RD_H = 4'd9,
    ST_SNAP_WT_H = 4'd10
  } timer_state_e;

endpackage

// File: rtl/sys_timer_master.sv
// -----------------------------------------------------------------------------
// sys_timer_master
// Avalon-MM initiator that services the system interval-timer slave without
// CPU involvement: enables the timer IRQ, waits for it, clears the timeout
// status and counts serviced timeouts in a hardware tick counter.
//
// Build option: TIMER_SNAPSHOT_EN
//   defined   : after each status clear the counter snapshot is latched (write
//               addr4) and read back (addr4, addr5); snapshot/snapshot_valid
//               ports are present.
//   undefined : no snapshot states or ports; addr4/5 are never accessed.
//
// Parameters
//   TICK_W        width of tick_count
//   READ_LATENCY  cycles from read request to valid readdata (1..3)
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   enable           level: 1 = service timer, 0 = disable timer IRQ and idle
//   av_address       slave register address
//   av_chipselect    access strobe, one cycle per access (no waitrequest)
//   av_write_n       0 = write, 1 = read (valid with av_chipselect)
//   av_writedata     write data
//   av_readdata      slave registered read data
//   timer_irq        slave interrupt (level)
//   tick             one-cycle pulse per serviced timeout
//   tick_count       serviced timeouts since reset, wraps
//   busy             1 whenever the FSM is not in IDLE or WAIT_IRQ
//   snapshot         {hi[7:0], lo[15:0]} of last counter snapshot (option)
//   snapshot_valid   pulses with tick (option)
//
// Bus handshake: all bus outputs are decoded from the state register alone,
// so an asynchronous reset returns the bus to idle in the same instant and
// no partially issued access can complete. Each access occupies exactly one
// cycle with av_chipselect high; read data is sampled exactly READ_LATENCY
// cycles after the request cycle.
// -----------------------------------------------------------------------------
module sys_timer_master
  import sys_timer_pkg::*;
#(
  parameter int TICK_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              timer_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy
`ifdef TIMER_SNAPSHOT_EN
  ,
  output logic [23:0]       snapshot,
  output logic              snapshot_valid
`endif
);

  timer_state_e      state_q, state_d;
  logic [TICK_W-1:0] tick_count_q;

`ifdef TIMER_SNAPSHOT_EN
  // Wait-state down-counter: loaded in the read-request cycle so that the
  // wait state ends exactly READ_LATENCY cycles after the request.
  localparam logic [1:0] RL_LOAD = 2'(READ_LATENCY - 1);

  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] snap_lo_q;
  logic [23:0] snapshot_q;
`else
  // Read data and read latency only matter for the snapshot sequence.
  logic unused_rd;
  assign unused_rd = ^{av_readdata, 2'(READ_LATENCY)};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
`ifdef TIMER_SNAPSHOT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE:     if (enable) state_d = ST_EN_CTRL;
      ST_EN_CTRL:  state_d = ST_WAIT_IRQ;
      // A pending irq wins over a disable so no timeout is left unserviced.
      ST_WAIT_IRQ: begin
        if (timer_irq)    state_d = ST_CLR;
        else if (!enable) state_d = ST_DIS_CTRL;
      end
`ifdef TIMER_SNAPSHOT_EN
      ST_CLR:      state_d = ST_SNAP_WR;
      ST_SNAP_WR:  state_d = ST_SNAP_RD_L;
      ST_SNAP_RD_L: begin
        wait_cnt_d = RL_LOAD;
        state_d    = ST_SNAP_WT_L;
      end
      ST_SNAP_WT_L: begin
        if (wait_cnt_q == 2'd0) state_d = ST_SNAP_RD_H;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      ST_SNAP_RD_H: begin
        wait_cnt_d = RL_LOAD;
        state_d    = ST_SNAP_WT_H;
      end
      ST_SNAP_WT_H: begin
        if (wait_cnt_q == 2'd0) state_d = ST_GUARD;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
`else
      ST_CLR:      state_d = ST_GUARD;
`endif
      // GUARD absorbs the cycle in which the slave irq is still high after
      // the status clear, so one timeout is never counted twice.
      ST_GUARD:    state_d = enable ? ST_WAIT_IRQ : ST_DIS_CTRL;
      ST_DIS_CTRL: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (Moore, from state_q only)
  // ---------------------------------------------------------------------------
  always_comb begin
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = REG_STATUS;
    av_writedata  = 16'h0000;
    tick          = 1'b0;
    case (state_q)
      ST_EN_CTRL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_CONTROL;
        av_writedata  = CTRL_ITO_MASK;
      end
      ST_CLR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_STATUS;
      end
      ST_DIS_CTRL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_CONTROL;
      end
`ifdef TIMER_SNAPSHOT_EN
      ST_SNAP_WR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_SNAPL;
      end
      ST_SNAP_RD_L: begin
        av_chipselect = 1'b1;
        av_address    = REG_SNAPL;
      end
      ST_SNAP_RD_H: begin
        av_chipselect = 1'b1;
        av_address    = REG_SNAPH;
      end
`endif
      ST_GUARD: tick = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_WAIT_IRQ);

  // ---------------------------------------------------------------------------
  // Tick counter: wraps from all-ones to zero
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_count_q <= '0;
    end else if (state_q == ST_GUARD) begin
      tick_count_q <= tick_count_q + TICK_W'(1);
    end
  end

  assign tick_count = tick_count_q;

`ifdef TIMER_SNAPSHOT_EN
  // ---------------------------------------------------------------------------
  // Snapshot capture: low half at the end of the first wait, then the full
  // value at the end of the second wait, so it is visible during GUARD.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= 2'd0;
      snap_lo_q  <= 16'h0000;
      snapshot_q <= 24'h000000;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (state_q == ST_SNAP_WT_L && wait_cnt_q == 2'd0) begin
        snap_lo_q <= av_readdata;
      end
      if (state_q == ST_SNAP_WT_H && wait_cnt_q == 2'd0) begin
        snapshot_q <= {av_readdata[7:0], snap_lo_q};
      end
    end
  end

  assign snapshot       = snapshot_q;
  assign snapshot_valid = (state_q == ST_GUARD);
`endif

endmodule

// File: tb/tb_sys_timer_master.sv
// -----------------------------------------------------------------------------
// tb_sys_timer_master
// Directed bench for sys_timer_master with a behavioural timer slave
// (registered 1-cycle readdata, irq drops one cycle after a status write).
// Expected bus accesses and tick_count values are queued by the stimulus;
// a negedge monitor pops and compares whenever the DUT drives an access or
// pulses tick. Build with +define+TIMER_SNAPSHOT_EN to cover the snapshot path.
// -----------------------------------------------------------------------------
module tb_sys_timer_master;

  localparam int TICK_W = 32;
  localparam int RL     = 1;
`ifdef TIMER_SNAPSHOT_EN
  localparam int FIRST_TICK_LAT = 4 + 1 + 2 * (1 + RL);
`else
  localparam int FIRST_TICK_LAT = 4;
`endif
  localparam logic [23:0] SNAP_VAL = 24'h98967F;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              enable;
  logic [2:0]        av_address;
  logic              av_chipselect;
  logic              av_write_n;
  logic [15:0]       av_writedata;
  logic [15:0]       av_readdata = 16'h0000;
  logic              timer_irq = 1'b0;
  logic              tick;
  logic [TICK_W-1:0] tick_count;
  logic              busy;
`ifdef TIMER_SNAPSHOT_EN
  logic [23:0]       snapshot;
  logic              snapshot_valid;
`endif

  sys_timer_master #(.TICK_W(TICK_W), .READ_LATENCY(RL)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .av_address    (av_address),
    .av_chipselect (av_chipselect),
    .av_write_n    (av_write_n),
    .av_writedata  (av_writedata),
    .av_readdata   (av_readdata),
    .timer_irq     (timer_irq),
    .tick          (tick),
    .tick_count    (tick_count),
    .busy          (busy)
`ifdef TIMER_SNAPSHOT_EN
    ,
    .snapshot      (snapshot),
    .snapshot_valid(snapshot_valid)
`endif
  );

  // ---------------------------------------------------------------------------
  // Timer slave model
  // ---------------------------------------------------------------------------
  logic irq_set = 1'b0;
  logic clr_d1  = 1'b0;

  always @(posedge clk) begin
    if (av_chipselect && av_write_n) begin
      case (av_address)
        3'd4:    av_readdata <= SNAP_VAL[15:0];
        3'd5:    av_readdata <= {8'h00, SNAP_VAL[23:16]};
        default: av_readdata <= 16'h0000;
      endcase
    end
    clr_d1 <= av_chipselect && !av_write_n && (av_address == 3'd0);
    if (clr_d1)       timer_irq <= 1'b0;
    else if (irq_set) timer_irq <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int ticks_seen = 0;
  logic tick_prev = 1'b0;

  logic [19:0]       exp_q[$];   // {write_n, address, writedata}
  logic [TICK_W-1:0] tick_q[$];  // tick_count after each tick

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (av_chipselect) begin
        if (exp_q.size() == 0)
          check("bus_unexpected", {12'h000, av_write_n, av_address, av_writedata}, 32'hFFFFFFFF);
        else
          check("bus_access", {12'h000, av_write_n, av_address, av_writedata}, {12'h000, exp_q.pop_front()});
      end
      if (tick_prev) begin
        if (tick_q.size() == 0) check("tick_unexpected", tick_count, 32'hDEADBEEF);
        else                    check("tick_count", tick_count, tick_q.pop_front());
      end
`ifdef TIMER_SNAPSHOT_EN
      if (tick) begin
        check("snapshot_valid", {31'd0, snapshot_valid}, 32'd1);
        check("snapshot", {8'h00, snapshot}, {8'h00, SNAP_VAL});
      end
`endif
      if (tick) ticks_seen++;
      tick_prev = tick;
    end else begin
      tick_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_service(input logic [TICK_W-1:0] cnt_after);
    exp_q.push_back({1'b0, 3'd0, 16'h0000});
`ifdef TIMER_SNAPSHOT_EN
    exp_q.push_back({1'b0, 3'd4, 16'h0000});
    exp_q.push_back({1'b1, 3'd4, 16'h0000});
    exp_q.push_back({1'b1, 3'd5, 16'h0000});
`endif
    tick_q.push_back(cnt_after);
  endtask

  task automatic raise_irq();
    @(negedge clk);
    irq_set = 1'b1;
    @(negedge clk);
    irq_set = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int cyc;
    cyc = 0;
    while (ticks_seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (ticks_seen < n) check("tick_timeout", ticks_seen, n);
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    reset   = 1'b1;
    enable  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs",   {31'd0, av_chipselect}, 32'd0);
    check("rst_wn",   {31'd0, av_write_n}, 32'd1);
    check("rst_addr", {29'd0, av_address}, 32'd0);
    check("rst_wd",   {16'd0, av_writedata}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_cnt",  tick_count, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef TIMER_SNAPSHOT_EN
    check("rst_snap",  {8'h00, snapshot}, 32'd0);
    check("rst_snapv", {31'd0, snapshot_valid}, 32'd0);
`endif

    // Reset asserted during the EN_CTRL write
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("en_ctrl_cs",   {31'd0, av_chipselect}, 32'd1);
    check("en_ctrl_addr", {29'd0, av_address}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_cs",   {31'd0, av_chipselect}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({1'b0, 3'd1, 16'h0001});
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("wait_irq_busy", {31'd0, busy}, 32'd0);
    check("reissue_drained", exp_q.size(), 32'd0);

    // Three irq pulses, one tick each
    for (int i = 1; i <= 3; i++) begin
      push_service(TICK_W'(i));
      raise_irq();
      wait_ticks(i);
    end
    repeat (10) @(negedge clk);
    check("three_irq_cnt", tick_count, 32'd3);
    check("three_irq_ticks", ticks_seen, 32'd3);

    // enable dropped while the status clear is on the bus
    push_service(TICK_W'(4));
    exp_q.push_back({1'b0, 3'd1, 16'h0000});
    raise_irq();
    cyc = 0;
    while (!(av_chipselect && !av_write_n && av_address == 3'd0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("clr_seen", {31'd0, av_chipselect}, 32'd1);
    enable = 1'b0;
    wait_ticks(4);
    repeat (6) @(negedge clk);
    check("drop_busy", {31'd0, busy}, 32'd0);
    check("drop_cnt",  tick_count, 32'd4);
    check("drop_drained", exp_q.size(), 32'd0);

    // irq already high before enable: serviced straight after EN_CTRL
    raise_irq();
    repeat (2) @(negedge clk);
    exp_q.push_back({1'b0, 3'd1, 16'h0001});
    push_service(TICK_W'(5));
    enable = 1'b1;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (tick) break;
    end
    check("first_tick_latency", cyc, FIRST_TICK_LAT);
    repeat (4) @(negedge clk);
    check("held_irq_cnt", tick_count, 32'd5);

    // Wrap from all-ones
    @(negedge clk);
    force dut.tick_count_q = {TICK_W{1'b1}};
    @(negedge clk);
    release dut.tick_count_q;
    @(negedge clk);
    check("preload_cnt", tick_count, 32'hFFFFFFFF);
    push_service('0);
    raise_irq();
    wait_ticks(6);
    check("wrap_cnt", tick_count, 32'd0);

    repeat (5) @(negedge clk);
    check("bus_q_empty",  exp_q.size(), 32'd0);
    check("tick_q_empty", tick_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
